// File: rtl/audio_in_44_1khz.sv
// rtl/audio_in_44_1khz.sv - stereo 1-bit delta-sigma capture, boxcar decimation to packed PCM
//
// Purpose: counts ones in each 2^AUDIO_BITS-cycle window of the left/right
// modulator bitstreams and presents one packed stereo word per window.
// Ports:
//   clk_audio  - audio clock (44.1 kHz x 2^AUDIO_BITS)
//   aclr       - asynchronous active-high reset
//   pll_locked - low clears all state synchronously and holds it clear
//   left_in    - left modulator bitstream
//   right_in   - right modulator bitstream
//   rreq       - read request, consumes the word when valid=1
//   sample     - {left, right} unsigned offset-binary PCM
//   valid      - sample holds an unread word
//   overrun    - sticky, an unread word was overwritten
// Optional: define AUDIO_IN_SYNC_EN to pass the inputs through 2-flop synchronizers.
module audio_in_44_1khz #(
    parameter int AUDIO_BITS = 12
) (
    input  logic                    clk_audio,
    input  logic                    aclr,
    input  logic                    pll_locked,
    input  logic                    left_in,
    input  logic                    right_in,
    input  logic                    rreq,
    output logic [2*AUDIO_BITS-1:0] sample,
    output logic                    valid,
    output logic                    overrun
);
    localparam int B = AUDIO_BITS;

    logic [B-1:0]   cnt_q, cnt_d;
    logic [B:0]     left_acc_q, left_acc_d;
    logic [B:0]     right_acc_q, right_acc_d;
    logic [2*B-1:0] sample_q, sample_d;
    logic           valid_q, valid_d;
    logic           overrun_q, overrun_d;

    logic           l_bit, r_bit;
    logic           win_end;
    logic [B:0]     l_tot, r_tot;
    logic [B-1:0]   l_sat, r_sat;

`ifdef AUDIO_IN_SYNC_EN
    logic l_s1_q, l_s1_d, l_s2_q, l_s2_d;
    logic r_s1_q, r_s1_d, r_s2_q, r_s2_d;

    always_comb begin
        l_s1_d = 1'b0;
        l_s2_d = 1'b0;
        r_s1_d = 1'b0;
        r_s2_d = 1'b0;
        if (pll_locked) begin
            l_s1_d = left_in;
            l_s2_d = l_s1_q;
            r_s1_d = right_in;
            r_s2_d = r_s1_q;
        end
    end

    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            l_s1_q <= 1'b0;
            l_s2_q <= 1'b0;
            r_s1_q <= 1'b0;
            r_s2_q <= 1'b0;
        end else begin
            l_s1_q <= l_s1_d;
            l_s2_q <= l_s2_d;
            r_s1_q <= r_s1_d;
            r_s2_q <= r_s2_d;
        end
    end

    assign l_bit = l_s2_q;
    assign r_bit = r_s2_q;
`else
    assign l_bit = left_in;
    assign r_bit = right_in;
`endif

    assign win_end = &cnt_q;

    // Window total includes the end cycle's own bit; the single value 2^B
    // (every bit set) does not fit in B bits and is clamped to full scale.
    assign l_tot = left_acc_q + {{B{1'b0}}, l_bit};
    assign r_tot = right_acc_q + {{B{1'b0}}, r_bit};
    assign l_sat = l_tot[B] ? {B{1'b1}} : l_tot[B-1:0];
    assign r_sat = r_tot[B] ? {B{1'b1}} : r_tot[B-1:0];

    always_comb begin
        cnt_d       = '0;
        left_acc_d  = '0;
        right_acc_d = '0;
        sample_d    = '0;
        valid_d     = 1'b0;
        overrun_d   = 1'b0;
        if (pll_locked) begin
            cnt_d     = cnt_q + 1'b1;
            sample_d  = sample_q;
            valid_d   = valid_q;
            overrun_d = overrun_q;
            if (win_end) begin
                sample_d = {l_sat, r_sat};
                valid_d  = 1'b1;
                // A read on the end cycle takes the old word, so nothing is lost.
                if (valid_q)
                    overrun_d = ~rreq;
            end else begin
                left_acc_d  = l_tot;
                right_acc_d = r_tot;
                if (rreq && valid_q) begin
                    valid_d   = 1'b0;
                    overrun_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_audio or posedge aclr) begin
        if (aclr) begin
            cnt_q       <= '0;
            left_acc_q  <= '0;
            right_acc_q <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            left_acc_q  <= left_acc_d;
            right_acc_q <= right_acc_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign sample  = sample_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_audio_in_44_1khz.sv
// tb/tb_audio_in_44_1khz.sv - directed self-checking bench for audio_in_44_1khz
module tb_audio_in_44_1khz;
    logic       clk_audio = 1'b0;
    logic       aclr = 1'b1;
    logic       pll_locked = 1'b1;
    logic       left_in = 1'b0;
    logic       right_in = 1'b0;
    logic       rreq = 1'b0;
    logic [7:0] sample;
    logic       valid;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    audio_in_44_1khz #(.AUDIO_BITS(4)) dut (
        .clk_audio (clk_audio),
        .aclr      (aclr),
        .pll_locked(pll_locked),
        .left_in   (left_in),
        .right_in  (right_in),
        .rreq      (rreq),
        .sample    (sample),
        .valid     (valid),
        .overrun   (overrun)
    );

    always #5 clk_audio = ~clk_audio;

    task automatic tick();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] s, input logic v, input logic o);
        chk({tag, "_sample"}, {24'd0, sample}, {24'd0, s});
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
        chk({tag, "_overrun"}, {31'd0, overrun}, {31'd0, o});
    endtask

    // One full 16-cycle window; bit i of each pattern is driven on cycle i.
    task automatic window(input string tag, input logic [15:0] lpat, input logic [15:0] rpat,
                          input logic rq_first, input logic rq_last);
        for (int i = 0; i < 16; i++) begin
            left_in  = lpat[i];
            right_in = rpat[i];
            rreq     = (i == 0) ? rq_first : ((i == 15) ? rq_last : 1'b0);
            tick();
            if (i == 0 && rq_first) begin
                chk({tag, "_rd_valid"}, {31'd0, valid}, 32'd0);
                chk({tag, "_rd_overrun"}, {31'd0, overrun}, 32'd0);
            end
        end
        rreq = 1'b0;
    endtask

    initial begin
        #23;
        chk_out("reset", 8'h00, 1'b0, 1'b0);
        @(posedge clk_audio);
        #1 aclr = 1'b0;

        // Saturation: all ones for 16 cycles gives total 16 -> 15.
        left_in  = 1'b1;
        right_in = 1'b1;
        repeat (15) tick();
        chk("sat_early_valid", {31'd0, valid}, 32'd0);
        tick();
        chk_out("sat", 8'hFF, 1'b1, 1'b0);

        window("lr10_a", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        chk_out("lr10_a", 8'hF0, 1'b1, 1'b0);
        window("lr10_b", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        chk_out("lr10_b", 8'hF0, 1'b1, 1'b0);

        // Alternating left (8 ones), right every 4th cycle (4 ones).
        window("toggle", 16'h5555, 16'h1111, 1'b1, 1'b0);
        chk_out("toggle", 8'h84, 1'b1, 1'b0);

        // Unread word overwritten.
        window("ovr", 16'h0000, 16'hFFFF, 1'b0, 1'b0);
        chk_out("ovr", 8'h0F, 1'b1, 1'b1);

        // Read clears both flags one edge later.
        window("after_rd", 16'h00FF, 16'h0007, 1'b1, 1'b0);
        chk_out("after_rd", 8'h83, 1'b1, 1'b0);

        window("ovr2", 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk_out("ovr2", 8'h00, 1'b1, 1'b1);

        // Read on the window-end cycle: new word valid, overrun cleared.
        window("rd_end", 16'h0003, 16'h0001, 1'b0, 1'b1);
        chk_out("rd_end", 8'h21, 1'b1, 1'b0);

        // Lock loss mid-window at count 7 for 3 cycles.
        left_in  = 1'b1;
        right_in = 1'b1;
        repeat (7) tick();
        pll_locked = 1'b0;
        tick();
        chk_out("unlock", 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        chk_out("unlock_hold", 8'h00, 1'b0, 1'b0);
        pll_locked = 1'b1;
        repeat (15) tick();
        chk("relock_early_valid", {31'd0, valid}, 32'd0);
        tick();
        chk_out("relock", 8'hFF, 1'b1, 1'b0);

        // Same disturbance via aclr, which acts without a clock edge.
        repeat (7) tick();
        #2 aclr = 1'b1;
        #1;
        chk_out("aclr_async", 8'h00, 1'b0, 1'b0);
        repeat (3) tick();
        chk_out("aclr_hold", 8'h00, 1'b0, 1'b0);
        aclr = 1'b0;
        repeat (15) tick();
        chk("aclr_early_valid", {31'd0, valid}, 32'd0);
        tick();
        chk_out("after_aclr", 8'hFF, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
